// File: rtl/bcd_display_driver.sv
// Sequential double-dabble binary-to-BCD converter driving three 7-segment digits.
// One shift per clock behind a valid/ready handshake; displays hold until the next result.
module bcd_display_driver #(
    parameter int DATA_WIDTH      = 16,
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter bit LEAD_ZERO_BLANK = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_value,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  done,
    output logic                  overflow,
    output logic [6:0]            outputA,
    output logic [6:0]            outputB,
    output logic [6:0]            outputC
);

    localparam int         CNT_W     = $clog2(DATA_WIDTH + 1);
    localparam logic [6:0] SEG_BLANK = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [6:0] SEG_DASH  = 7'h40;

    typedef enum logic [1:0] {IDLE, SHIFT, UPDATE} state_t;

    state_t                state, next_state;
    logic [DATA_WIDTH-1:0] bin_sr;
    logic [11:0]           bcd, bcd_adj;
    logic [CNT_W-1:0]      cnt;
    logic                  ovf_pending;
    logic                  accept;
    logic [3:0]            hund, tens, units;
    logic [6:0]            seg_a, seg_b, seg_c;

    function automatic logic [6:0] seg_encode(input logic [3:0] digit);
        case (digit)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    function automatic logic [6:0] seg_drive(input logic [6:0] seg);
        return ACTIVE_LOW ? ~seg : seg;
    endfunction

    assign in_ready = (state == IDLE);
    assign accept   = in_valid && in_ready;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = SHIFT;
            SHIFT:   if (cnt == CNT_W'(1)) next_state = UPDATE;
            UPDATE:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Add-3 correction on every nibble that would reach 10 or more after the shift
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 3; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    assign hund  = bcd[11:8];
    assign tens  = bcd[7:4];
    assign units = bcd[3:0];

    always_comb begin
        seg_a = seg_encode(hund);
        seg_b = seg_encode(tens);
        seg_c = seg_encode(units);
        if (ovf_pending) begin
            seg_a = SEG_DASH;
            seg_b = SEG_DASH;
            seg_c = SEG_DASH;
        end else if (LEAD_ZERO_BLANK) begin
            if (hund == 4'd0)
                seg_a = 7'h00;
            if (hund == 4'd0 && tens == 4'd0)
                seg_b = 7'h00;
        end
    end

    // Conversion datapath: no reset needed, always reloaded on accept
    always_ff @(posedge clock) begin
        if (accept) begin
            bin_sr      <= in_value;
            bcd         <= '0;
            cnt         <= CNT_W'(DATA_WIDTH);
            ovf_pending <= (32'(in_value) > 32'd999);
        end else if (state == SHIFT) begin
            {bcd, bin_sr} <= {bcd_adj, bin_sr} << 1;
            cnt           <= cnt - CNT_W'(1);
        end
    end

    // Control and display registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            done     <= 1'b0;
            overflow <= 1'b0;
            outputA  <= SEG_BLANK;
            outputB  <= SEG_BLANK;
            outputC  <= SEG_BLANK;
        end else begin
            state <= next_state;
            done  <= (state == UPDATE);
            if (state == UPDATE) begin
                overflow <= ovf_pending;
                outputA  <= seg_drive(seg_a);
                outputB  <= seg_drive(seg_b);
                outputC  <= seg_drive(seg_c);
            end
        end
    end

endmodule
